// File: rtl/tmr_voter_monitor.sv
// tmr_voter_monitor: registered N-way bitwise majority voter with per-channel OK/SUSPECT/FAILED monitoring.
// Optional VOTER_MASK_EN: FAILED channels drop out of the vote; tied bits hold their previous value.
module tmr_voter_monitor #(
    parameter int NUM_CH       = 3,
    parameter int WIDTH        = 8,
    parameter int FAULT_THRESH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_CH*WIDTH-1:0]   CH_DATA,
    input  logic                      IN_VALID,
    input  logic [NUM_CH-1:0]         CLR_FAULT,
    output logic [WIDTH-1:0]          VOTED,
    output logic                      OUT_VALID,
    output logic                      DISAGREE,
    output logic [NUM_CH-1:0]         CH_SUSPECT,
    output logic [NUM_CH-1:0]         CH_FAILED
);
    localparam int CW = $clog2(FAULT_THRESH + 1);
    localparam int VW = $clog2(NUM_CH + 1) + 1;

    typedef enum logic [1:0] {OK, SUSPECT, FAILED} state_t;

    state_t            st  [NUM_CH];
    logic [CW-1:0]     cnt [NUM_CH];
    logic [NUM_CH-1:0] vote_en;
    logic [NUM_CH-1:0] mismatch;
    logic [WIDTH-1:0]  vote;
    logic [VW-1:0]     ones;
    logic [VW-1:0]     nv;

`ifdef VOTER_MASK_EN
    assign vote_en = ~CH_FAILED;
`else
    assign vote_en = '1;
`endif

    // Twice the ones count against the voter count; equality is a tie and keeps the old bit.
    always_comb begin
        vote = VOTED;
        ones = '0;
        nv   = '0;
        for (int b = 0; b < WIDTH; b++) begin
            ones = '0;
            nv   = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ones = ones + VW'(vote_en[i] & CH_DATA[i*WIDTH + b]);
                nv   = nv + VW'(vote_en[i]);
            end
            vote[b] = ((ones << 1) > nv) ? 1'b1 : ((ones << 1) == nv) ? VOTED[b] : 1'b0;
        end
    end

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NUM_CH; i++)
            mismatch[i] = IN_VALID && (CH_DATA[i*WIDTH +: WIDTH] != vote);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            VOTED     <= '0;
            OUT_VALID <= 1'b0;
            DISAGREE  <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID) begin
                VOTED    <= vote;
                DISAGREE <= |(mismatch & vote_en);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st[i]  <= OK;
                cnt[i] <= '0;
            end
            CH_SUSPECT <= '0;
            CH_FAILED  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CLR_FAULT[i]) begin
                    st[i]         <= OK;
                    cnt[i]        <= '0;
                    CH_SUSPECT[i] <= 1'b0;
                    CH_FAILED[i]  <= 1'b0;
                end else if (IN_VALID) begin
                    case (st[i])
                        OK: if (mismatch[i]) begin
                            st[i]         <= SUSPECT;
                            cnt[i]        <= CW'(1);
                            CH_SUSPECT[i] <= 1'b1;
                        end
                        SUSPECT: if (mismatch[i]) begin
                            cnt[i] <= cnt[i] + CW'(1);
                            if (cnt[i] + CW'(1) == CW'(FAULT_THRESH)) begin
                                st[i]         <= FAILED;
                                CH_SUSPECT[i] <= 1'b0;
                                CH_FAILED[i]  <= 1'b1;
                            end
                        end else begin
                            cnt[i] <= cnt[i] - CW'(1);
                            if (cnt[i] == CW'(1)) begin
                                st[i]         <= OK;
                                CH_SUSPECT[i] <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_tmr_voter_monitor.sv
// tb_tmr_voter_monitor: vector table, directed corner sequences and random stimulus against a count-based model.
module tb_tmr_voter_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] ch_data;
    logic        in_valid;
    logic [2:0]  clr_fault;
    logic [7:0]  voted;
    logic        out_valid;
    logic        disagree;
    logic [2:0]  ch_suspect;
    logic [2:0]  ch_failed;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_voted;
    logic       m_valid;
    logic       m_dis;
    int         m_bad [3];

    typedef struct {
        logic [23:0] d;
        logic        v;
        logic [2:0]  clr;
        logic [7:0]  e_voted;
        logic        e_valid;
        logic        e_dis;
        logic [2:0]  e_sus;
        logic [2:0]  e_fail;
    } vec_t;

    vec_t tbl [5];

    tmr_voter_monitor #(.NUM_CH(3), .WIDTH(8), .FAULT_THRESH(4)) dut (
        .CLK(clk), .RESET(rst), .CH_DATA(ch_data), .IN_VALID(in_valid), .CLR_FAULT(clr_fault),
        .VOTED(voted), .OUT_VALID(out_valid), .DISAGREE(disagree),
        .CH_SUSPECT(ch_suspect), .CH_FAILED(ch_failed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a channel's health is just its bad-sample count; FAILED is a count of 4 or more.
    function automatic logic m_failed(input int i);
        return m_bad[i] >= 4;
    endfunction

    function automatic logic m_suspect(input int i);
        return m_bad[i] > 0 && m_bad[i] < 4;
    endfunction

    task automatic model_reset();
        m_voted = 8'h00;
        m_valid = 1'b0;
        m_dis   = 1'b0;
        for (int i = 0; i < 3; i++) m_bad[i] = 0;
    endtask

    task automatic model_step(input logic [23:0] d, input logic v, input logic [2:0] clr);
        logic [7:0] vt;
        bit         en [3];
        int         ones;
        int         nv;
        bit         mm;
        for (int i = 0; i < 3; i++) begin
`ifdef VOTER_MASK_EN
            en[i] = !m_failed(i);
`else
            en[i] = 1'b1;
`endif
        end
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            nv   = 0;
            for (int i = 0; i < 3; i++) if (en[i]) begin
                nv++;
                ones += int'(d[i*8 + b]);
            end
            vt[b] = (ones > nv - ones) ? 1'b1 : (ones < nv - ones) ? 1'b0 : m_voted[b];
        end
        m_valid = v;
        if (v) begin
            m_voted = vt;
            m_dis   = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            mm = v && (d[i*8 +: 8] != vt);
            if (v && mm && en[i]) m_dis = 1'b1;
            if (clr[i]) m_bad[i] = 0;
            else if (v && !m_failed(i)) m_bad[i] = mm ? m_bad[i] + 1 : (m_bad[i] > 0 ? m_bad[i] - 1 : 0);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [2:0] s;
        logic [2:0] f;
        for (int i = 0; i < 3; i++) begin
            s[i] = m_suspect(i);
            f[i] = m_failed(i);
        end
        chk({tag, ".voted"}, 32'(voted), 32'(m_voted));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".disagree"}, 32'(disagree), 32'(m_dis));
        chk({tag, ".suspect"}, 32'(ch_suspect), 32'(s));
        chk({tag, ".failed"}, 32'(ch_failed), 32'(f));
    endtask

    task automatic step(input string tag, input logic [23:0] d, input logic v, input logic [2:0] clr);
        ch_data   = d;
        in_valid  = v;
        clr_fault = clr;
        @(posedge clk);
        model_step(d, v, clr);
        @(negedge clk);
        chk_model(tag);
        in_valid  = 1'b0;
        clr_fault = 3'b000;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".voted"}, 32'(voted), 0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".disagree"}, 32'(disagree), 0);
        chk({tag, ".suspect"}, 32'(ch_suspect), 0);
        chk({tag, ".failed"}, 32'(ch_failed), 0);
    endtask

    initial begin
        logic [7:0] base;
        logic [23:0] d;
        logic [2:0] c;
        rst = 1'b1;
        ch_data = '0;
        in_valid = 1'b0;
        clr_fault = '0;
        model_reset();
        tbl[0] = '{{8'hA5, 8'hA5, 8'hA5}, 1'b1, 3'b000, 8'hA5, 1'b1, 1'b0, 3'b000, 3'b000};
        tbl[1] = '{24'h000000,            1'b0, 3'b000, 8'hA5, 1'b0, 1'b0, 3'b000, 3'b000};
        tbl[2] = '{{8'hAA, 8'hCC, 8'hF0}, 1'b1, 3'b000, 8'hE8, 1'b1, 1'b1, 3'b111, 3'b000};
        tbl[3] = '{24'h000000,            1'b0, 3'b111, 8'hE8, 1'b0, 1'b1, 3'b000, 3'b000};
        tbl[4] = '{{8'h5A, 8'h5A, 8'h5A}, 1'b1, 3'b000, 8'h5A, 1'b1, 1'b0, 3'b000, 3'b000};

        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("idle_after_reset");

        for (int k = 0; k < 5; k++) begin
            ch_data   = tbl[k].d;
            in_valid  = tbl[k].v;
            clr_fault = tbl[k].clr;
            @(posedge clk);
            model_step(tbl[k].d, tbl[k].v, tbl[k].clr);
            @(negedge clk);
            chk($sformatf("tbl%0d.voted", k), 32'(voted), 32'(tbl[k].e_voted));
            chk($sformatf("tbl%0d.out_valid", k), 32'(out_valid), 32'(tbl[k].e_valid));
            chk($sformatf("tbl%0d.disagree", k), 32'(disagree), 32'(tbl[k].e_dis));
            chk($sformatf("tbl%0d.suspect", k), 32'(ch_suspect), 32'(tbl[k].e_sus));
            chk($sformatf("tbl%0d.failed", k), 32'(ch_failed), 32'(tbl[k].e_fail));
        end
        in_valid = 1'b0;
        clr_fault = '0;

        // Fault path on ch2.
        for (int k = 0; k < 4; k++) begin
            step("fault", {8'h00, 8'h5A, 8'h5A}, 1'b1, 3'b000);
            if (k == 0) chk("fault.suspect_after1", 32'(ch_suspect[2]), 1);
        end
        chk("fault.failed_after4", 32'(ch_failed[2]), 1);
        for (int k = 0; k < 10; k++) step("sticky", {8'h5A, 8'h5A, 8'h5A}, 1'b1, 3'b000);
        chk("sticky.failed", 32'(ch_failed[2]), 1);
        step("clr", 24'h0, 1'b0, 3'b100);
        chk("clr.failed", 32'(ch_failed[2]), 0);

        // Recovery on ch1.
        step("rec_mm1", {8'h5A, 8'h00, 8'h5A}, 1'b1, 3'b000);
        chk("rec.suspect1", 32'(ch_suspect[1]), 1);
        step("rec_mm2", {8'h5A, 8'h00, 8'h5A}, 1'b1, 3'b000);
        step("rec_ok1", {8'h5A, 8'h5A, 8'h5A}, 1'b1, 3'b000);
        chk("rec.still_suspect", 32'(ch_suspect[1]), 1);
        step("rec_ok2", {8'h5A, 8'h5A, 8'h5A}, 1'b1, 3'b000);
        chk("rec.ok", 32'({ch_suspect[1], ch_failed[1]}), 0);

        // Fail ch2 again, then split vote between ch0 and ch1.
        for (int k = 0; k < 4; k++) step("refail", {8'h00, 8'h5A, 8'h5A}, 1'b1, 3'b000);
        step("split", {8'h00, 8'h0F, 8'hFF}, 1'b1, 3'b000);
`ifdef VOTER_MASK_EN
        chk("split.voted_hold_upper", 32'(voted), 32'h5F);
`else
        chk("split.voted_majority", 32'(voted), 32'h0F);
`endif
        step("clr_vs_mm", {8'h00, 8'h5A, 8'h5A}, 1'b1, 3'b100);
        chk("clr_vs_mm.ch2", 32'({ch_suspect[2], ch_failed[2]}), 0);
        step("after_clr", {8'h5A, 8'h5A, 8'h5A}, 1'b1, 3'b000);
        chk("after_clr.ch2", 32'({ch_suspect[2], ch_failed[2]}), 0);

        // Async reset mid-clock, with a valid sample in flight.
        ch_data = {8'hA5, 8'hA5, 8'hA5};
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1 chk_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_zero("reset_discard");
        in_valid = 1'b0;
        rst = 1'b0;
        step("post_reset_idle", 24'h0, 1'b0, 3'b000);
        chk_zero("post_reset_idle_zero");

        for (int k = 0; k < 400; k++) begin
            base = 8'($urandom);
            for (int i = 0; i < 3; i++) d[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
            for (int i = 0; i < 3; i++) c[i] = ($urandom_range(0, 15) == 0);
            step($sformatf("rnd%0d", k), d, 1'($urandom_range(0, 3) != 0), c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
